uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal baud divider, configurable frame format and a small input FIFO.
- Successor to the fixed-8N1 transmitter and its separate tx clock generator.
- Runs entirely on the system clock, with a per-bit enable instead of a derived clock.
- Accepts words from the host over a valid/ready handshake.
- Drives serial TX, to be wired to a receiver's RX.

Parameters:
- CLK_DIV, 16: system clock cycles per serial bit; must be ≥ 2.
- DATA_BITS, 8: data bits per frame, 5 to 9; sent LSB first.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- tx_enable, input, 1: when 1, new frames may start. When 0, no new frame starts; a frame already in flight completes.
- ld_tx_data, input, 1: write-valid; tx_data is pushed on any rising edge where ld_tx_data=1 and tx_ready=1.
- tx_data, input, DATA_BITS: word to transmit.
- tx_ready, output, 1: combinational, equal to !fifo_full.
- tx_empty, output, 1: 1 when the FIFO is empty and the FSM is in IDLE.
- tx_busy, output, 1: 1 whenever the FSM is not in IDLE.
- tx_out, output, 1: serial line; idles high. Registered.

Behaviour:
- Reset (synchronous, checked first every edge):
  - FIFO pointers and count go to 0.
  - FSM goes to IDLE; bit counter and baud counter go to 0.
  - tx_out=1, tx_busy=0, tx_empty=1, tx_ready=1.
  - Reset mid-frame aborts the frame immediately; tx_out returns high on the same edge.
- FIFO:
  - Write when ld_tx_data & tx_ready.
  - Pop happens only on the IDLE→START transition.
  - A write and a pop on the same edge are both honoured; the count is unchanged.
  - A write while full is dropped silently; FIFO contents are unaffected.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty and tx_enable=1, pop the head into a shift register, clear the baud counter, go to START, and register tx_out=0.
  - Every state except IDLE holds for exactly CLK_DIV cycles. The baud counter counts 0..CLK_DIV-1; the state advances on terminal count.
  - START→DATA.
  - DATA: tx_out = shift[0]; shift right at each bit boundary. After DATA_BITS bits, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx_out = ^data XOR PARITY_ODD.
  - STOP: tx_out=1 for STOP_BITS*CLK_DIV cycles. At the end:
    - If FIFO non-empty and tx_enable=1, go directly to START with no idle gap (back-to-back frames).
    - Otherwise go to IDLE.
- Timing:
  - Frame length is (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLK_DIV cycles.
  - Latency: a word written at edge N into an empty FIFO with the FSM in IDLE and tx_enable=1 is popped at edge N+1; tx_out is low after edge N+1.
- tx_enable deasserted:
  - Takes effect only at a frame boundary, i.e. in IDLE or at the end of STOP.
  - Never truncates a bit.
  - FIFO writes continue to be accepted while tx_enable=0.
- Parity is computed over the popped word, not over the live tx_data input.
- Unused upper bits do not exist; the datapath width is exactly DATA_BITS.

Test Plan:
- Reset then idle: hold reset 3 cycles → tx_out=1, tx_empty=1, tx_ready=1, tx_busy=0. No line activity for 100 cycles.
- Single frame (CLK_DIV=4, 8N1): write 8'h6E → tx_out low one edge later, then bits 0,1,1,1,0,1,1,0 at 4 cycles each, then stop 1. tx_busy high for exactly 40 cycles; tx_empty returns to 1.
- Back-to-back / full (FIFO_DEPTH=4): write 5 words in consecutive cycles → tx_ready drops after the 4th accepted word (the 1st already popped, 5th accepted). All frames are contiguous with no idle cycles between a stop bit and the next start bit. A write while tx_ready=0 is dropped.
- Parity/stop variants:
  - PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, word 8'h07 → parity bit 1, then two stop bits; frame = 12×CLK_DIV cycles.
  - Same with PARITY_ODD=1 → parity bit 0.
- tx_enable gating: load 2 words, drop tx_enable during the first frame's data bits → first frame completes intact, line stays high. Second frame starts one edge after tx_enable reasserts.
- Reset mid-frame: assert reset during DATA bit 3 → tx_out=1 after that edge, FIFO emptied. No further frames after reset releases until new writes arrive.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and an internal baud divider.
// Frame format (data width, parity, stop bits) is fixed at elaboration.
module uart_tx_fifo #(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 ld_tx_data,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_empty,
    output logic                 tx_busy,
    output logic                 tx_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic          PAR_INIT = (PARITY_ODD != 0);
    localparam logic          HAS_PARITY = (PARITY_EN != 0);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;

    logic [2:0]           state_reg;
    logic [CW-1:0]        baud_reg;
    logic [3:0]           bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 tx_out_reg;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 wr_en;
    logic                 pop;
    logic                 baud_tick;
    logic                 stop_done;
    logic [DATA_BITS-1:0] head;

    assign fifo_full  = (count_reg == FIFO_FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign wr_en      = ld_tx_data && !fifo_full;
    assign head       = mem[rd_ptr_reg];
    assign baud_tick  = (baud_reg == BAUD_LAST);
    assign stop_done  = (state_reg == S_STOP) && baud_tick && (bit_reg == STOP_LAST);

    // A new frame may only begin at a frame boundary: from IDLE or at the very end of STOP.
    assign pop = !fifo_empty && tx_enable && ((state_reg == S_IDLE) || stop_done);

    assign tx_ready = !fifo_full;
    assign tx_busy  = (state_reg != S_IDLE);
    assign tx_empty = fifo_empty && (state_reg == S_IDLE);
    assign tx_out   = tx_out_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            tx_out_reg <= 1'b1;
        end else begin
            baud_reg <= baud_tick ? '0 : baud_reg + CW'(1);
            case (state_reg)
                S_IDLE: begin
                    baud_reg   <= '0;
                    bit_reg    <= '0;
                    tx_out_reg <= 1'b1;
                    if (pop) begin
                        state_reg  <= S_START;
                        shift_reg  <= head;
                        parity_reg <= (^head) ^ PAR_INIT;
                        tx_out_reg <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        state_reg  <= S_DATA;
                        bit_reg    <= '0;
                        tx_out_reg <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        if (bit_reg == DATA_LAST) begin
                            bit_reg <= '0;
                            if (HAS_PARITY) begin
                                state_reg  <= S_PARITY;
                                tx_out_reg <= parity_reg;
                            end else begin
                                state_reg  <= S_STOP;
                                tx_out_reg <= 1'b1;
                            end
                        end else begin
                            // The line is registered, so present the next bit as we shift.
                            bit_reg    <= bit_reg + 4'd1;
                            shift_reg  <= shift_reg >> 1;
                            tx_out_reg <= shift_reg[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (baud_tick) begin
                        state_reg  <= S_STOP;
                        bit_reg    <= '0;
                        tx_out_reg <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (bit_reg == STOP_LAST) begin
                            bit_reg <= '0;
                            if (pop) begin
                                state_reg  <= S_START;
                                shift_reg  <= head;
                                parity_reg <= (^head) ^ PAR_INIT;
                                tx_out_reg <= 1'b0;
                            end else begin
                                state_reg  <= S_IDLE;
                                tx_out_reg <= 1'b1;
                            end
                        end else begin
                            bit_reg <= bit_reg + 4'd1;
                        end
                    end
                end
                default: begin
                    state_reg  <= S_IDLE;
                    tx_out_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: an 8N1 instance checked through a line monitor and
// expected-frame queue, plus 8E2/8O2 instances for the parity and stop-bit variants.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, tx_enable, ld_tx_data;
    logic [7:0] tx_data;
    logic       tx_ready, tx_empty, tx_busy, tx_out;

    logic       en_p, ld_pe, ld_po;
    logic [7:0] data_p;
    logic       rdy_pe, emp_pe, busy_pe, out_pe;
    logic       rdy_po, emp_po, busy_po, out_po;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .ld_tx_data(ld_tx_data),
        .tx_data(tx_data), .tx_ready(tx_ready), .tx_empty(tx_empty),
        .tx_busy(tx_busy), .tx_out(tx_out));

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_pe (
        .clk(clk), .reset(reset), .tx_enable(en_p), .ld_tx_data(ld_pe),
        .tx_data(data_p), .tx_ready(rdy_pe), .tx_empty(emp_pe),
        .tx_busy(busy_pe), .tx_out(out_pe));

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) dut_po (
        .clk(clk), .reset(reset), .tx_enable(en_p), .ld_tx_data(ld_po),
        .tx_data(data_p), .tx_ready(rdy_po), .tx_empty(emp_po),
        .tx_busy(busy_po), .tx_out(out_po));

    typedef struct { logic [7:0] data; logic [9:0] frame; } vec8_t;
    typedef struct { logic [7:0] data; logic [11:0] even_f; logic [11:0] odd_f; } vecp_t;

    int          vectors = 0;
    int          fails = 0;
    longint      cyc = 0;
    logic [11:0] sb[$];
    longint      starts[$];
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        vectors++;
        fails++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic logic line(input int sel);
        case (sel)
            0:       return tx_out;
            1:       return out_pe;
            default: return out_po;
        endcase
    endfunction

    function automatic logic busy(input int sel);
        case (sel)
            0:       return tx_busy;
            1:       return busy_pe;
            default: return busy_po;
        endcase
    endfunction

    // Waits up to max_wait negedges for a start bit, then samples each bit mid-period.
    task automatic capture(input int sel, input int nbits, input int max_wait,
                           output logic [11:0] f, output bit ok, output longint t_start);
        ok = 1'b0;
        f = '0;
        t_start = 0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (line(sel) === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            t_start = cyc;
            repeat (2) @(negedge clk);
            f[0] = line(sel);
            for (int b = 1; b < nbits; b++) begin
                repeat (CLK_DIV) @(negedge clk);
                f[b] = line(sel);
            end
        end
    endtask

    initial begin : monitor
        logic [11:0] f;
        bit          ok;
        longint      ts;
        forever begin
            capture(0, 10, 1, f, ok, ts);
            if (ok && mon_en) begin
                starts.push_back(ts);
                if (sb.size() == 0) begin
                    fail_now("unexpected_frame", $sformatf("got %0h expected none", f));
                end else begin
                    check("frame", {22'b0, f[9:0]}, {20'b0, sb.pop_front()});
                end
            end
        end
    end

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        ld_tx_data = 1'b1;
        tx_data = d;
        @(negedge clk);
        ld_tx_data = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_now(name, $sformatf("timeout after %0d cycles", budget));
        repeat (2) @(negedge clk);
    endtask

    task automatic parity_frame(input int sel, input logic [7:0] d, input logic [11:0] exp,
                                input string name);
        logic [11:0] f;
        bit          ok;
        longint      ts;
        int          busy_n;
        @(negedge clk);
        data_p = d;
        if (sel == 1) ld_pe = 1'b1;
        else ld_po = 1'b1;
        @(negedge clk);
        ld_pe = 1'b0;
        ld_po = 1'b0;
        busy_n = 0;
        fork
            capture(sel, 12, 20, f, ok, ts);
            begin
                for (int i = 0; i < 100; i++) begin
                    if (busy(sel) === 1'b1) busy_n++;
                    @(negedge clk);
                end
            end
        join
        if (!ok) fail_now(name, "no start bit");
        else check(name, {20'b0, f}, {20'b0, exp});
        check({name, "_len"}, busy_n, 48);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec8_t v8[6];
        vecp_t vp[2];
        int    bad;
        int    n;
        int    model_cnt;

        v8[0] = '{8'h00, 10'h200};
        v8[1] = '{8'hFF, 10'h3FE};
        v8[2] = '{8'hA5, 10'h34A};
        v8[3] = '{8'h01, 10'h202};
        v8[4] = '{8'h80, 10'h300};
        v8[5] = '{8'h6E, 10'h2DC};
        vp[0] = '{8'h07, 12'hE0E, 12'hC0E};
        vp[1] = '{8'h03, 12'hC06, 12'hE06};

        reset = 1'b1;
        tx_enable = 1'b1;
        ld_tx_data = 1'b0;
        tx_data = '0;
        en_p = 1'b1;
        ld_pe = 1'b0;
        ld_po = 1'b0;
        data_p = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx_out", tx_out, 1);
        check("reset_tx_empty", tx_empty, 1);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_tx_busy", tx_busy, 0);
        reset = 1'b0;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 0);
        mon_en = 1'b1;

        // Single frame: latency, busy duration, empty afterwards.
        sb.push_back({2'b0, 10'h2DC});
        write_word(8'h6E);
        check("pre_start_line", tx_out, 1);
        check("empty_after_write", tx_empty, 0);
        @(negedge clk);
        check("start_latency", tx_out, 0);
        n = 0;
        while (tx_busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", n, 40);
        check("empty_after_frame", tx_empty, 1);
        wait_idle("single_frame", 100);

        foreach (v8[i]) begin
            sb.push_back({2'b0, v8[i].frame});
            write_word(v8[i].data);
            wait_idle($sformatf("table_frame%0d", i), 200);
        end

        // Back-to-back: five consecutive writes fill the FIFO, a sixth is dropped.
        starts.delete();
        model_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ld_tx_data = 1'b1;
            tx_data = v8[i].data;
            sb.push_back({2'b0, v8[i].frame});
            model_cnt++;
            if (i == 1) model_cnt--;
            @(negedge clk);
            check($sformatf("b2b_ready%0d", i), tx_ready, (model_cnt < 4) ? 1 : 0);
        end
        tx_data = 8'h3C;
        @(negedge clk);
        check("full_drop_ready", tx_ready, 0);
        ld_tx_data = 1'b0;
        wait_idle("b2b", 400);
        check("b2b_frames", starts.size(), 5);
        bad = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != 40) bad++;
        end
        check("b2b_gap", bad, 0);

        // tx_enable gating at the frame boundary.
        sb.push_back({2'b0, v8[2].frame});
        sb.push_back({2'b0, v8[3].frame});
        write_word(v8[2].data);
        write_word(v8[3].data);
        repeat (10) @(negedge clk);
        tx_enable = 1'b0;
        n = 0;
        while (sb.size() > 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("gate_first_frame", "timeout");
        repeat (5) @(negedge clk);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || tx_empty !== 1'b0) bad++;
        end
        check("gated_quiet", bad, 0);
        tx_enable = 1'b1;
        @(negedge clk);
        check("reenable_start", tx_out, 0);
        wait_idle("gate_second_frame", 200);

        foreach (vp[i]) begin
            parity_frame(1, vp[i].data, vp[i].even_f, $sformatf("even_frame%0d", i));
            parity_frame(2, vp[i].data, vp[i].odd_f, $sformatf("odd_frame%0d", i));
        end

        // Reset during DATA bit 3 with a second word still queued.
        mon_en = 1'b0;
        write_word(8'h00);
        write_word(8'h55);
        repeat (15) @(negedge clk);
        check("pre_reset_line", tx_out, 0);
        check("pre_reset_busy", tx_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_tx_out", tx_out, 1);
        check("midreset_busy", tx_busy, 0);
        check("midreset_empty", tx_empty, 1);
        check("midreset_ready", tx_ready, 1);
        reset = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("post_reset_quiet", bad, 0);
        sb.delete();
        mon_en = 1'b1;
        sb.push_back({2'b0, v8[5].frame});
        write_word(v8[5].data);
        wait_idle("post_reset_frame", 200);
        check("final_empty", tx_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
